// File: rtl/fsm_step_display.sv
// Debounced-pushbutton stepped ring FSM with a scrolling per-digit ASCII message
// and LED echo of the synchronised switches and Z flags.
module fsm_step_display #(
  parameter int NUM_STATES      = 5,
  parameter int NUM_DIGITS      = 4,
  parameter int NUM_SW          = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 25000000
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic                          KEY0,
  input  logic [NUM_SW-1:0]             SW,
  output logic [$clog2(NUM_STATES)-1:0] STATE,
  output logic [1:0]                    Z,
  output logic [8*NUM_DIGITS-1:0]       CHARS,
  output logic [NUM_SW+1:0]             LED_SW
);

  localparam int STW = $clog2(NUM_STATES);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int CW  = $clog2(SCROLL_CYCLES + 1);
  localparam int RW  = $clog2(NUM_DIGITS);

  typedef logic [STW-1:0] state_t;
  typedef logic [DW-1:0]  dcnt_t;
  typedef logic [CW-1:0]  scnt_t;
  typedef logic [RW-1:0]  rot_t;

  localparam state_t LAST  = state_t'(NUM_STATES - 1);
  localparam dcnt_t  DLAST = dcnt_t'(DEBOUNCE_CYCLES - 1);
  localparam scnt_t  SLAST = scnt_t'(SCROLL_CYCLES - 1);
  localparam rot_t   RLAST = rot_t'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_HOLD,
    ACT_FWD,
    ACT_BACK
  } act_t;

  logic [NUM_SW-1:0] sw_meta, sw_sync;
  logic              key_meta, key_sync;
  dcnt_t             dcnt;
  logic              deb, deb_prev, step, armed;
  logic [1:0]        init_sr;
  state_t            state, state_nx;
  logic              z0, z0_nx;
  rot_t              rot, rot_nx;
  scnt_t             scnt, scnt_nx;
  act_t              act;
  logic [7:0]        base [NUM_DIGITS];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      key_meta <= KEY0;
      key_sync <= key_meta;
    end
  end

  // A press is only honoured once a genuine release has been debounced after
  // reset, so a key held through reset cannot produce a step.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      dcnt     <= '0;
      deb      <= 1'b1;
      deb_prev <= 1'b1;
      step     <= 1'b0;
      armed    <= 1'b0;
      init_sr  <= 2'b00;
    end else begin
      init_sr  <= {init_sr[0], 1'b1};
      deb_prev <= deb;
      step     <= armed & deb_prev & ~deb;
      if (init_sr[1] && key_sync && deb) begin
        armed <= 1'b1;
      end
      if (key_sync == deb) begin
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        deb  <= key_sync;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + dcnt_t'(1);
      end
    end
  end

  always_comb begin
    act = ACT_NONE;
    if (sw_sync[3]) begin
      act = ACT_CLEAR;
    end else if (step) begin
      if (sw_sync[1])      act = ACT_HOLD;
      else if (sw_sync[0]) act = ACT_FWD;
      else                 act = ACT_BACK;
    end
  end

  always_comb begin
    state_nx = state;
    z0_nx    = z0;
    rot_nx   = rot;
    scnt_nx  = scnt;
    if (act == ACT_CLEAR) begin
      state_nx = '0;
      z0_nx    = 1'b0;
      rot_nx   = '0;
      scnt_nx  = '0;
    end else begin
      if (sw_sync[2]) begin
        if (scnt == SLAST) begin
          scnt_nx = '0;
          rot_nx  = (rot == RLAST) ? '0 : rot + rot_t'(1);
        end else begin
          scnt_nx = scnt + scnt_t'(1);
        end
      end else begin
        scnt_nx = '0;
        rot_nx  = '0;
      end
      case (act)
        ACT_FWD: begin
          state_nx = (state == LAST) ? '0 : state + state_t'(1);
          z0_nx    = (state == LAST);
        end
        ACT_BACK: begin
          state_nx = (state == '0) ? LAST : state - state_t'(1);
          z0_nx    = (state == '0);
        end
        default: ;
      endcase
      // A new state always restarts the message unrotated.
      if (state_nx != state) begin
        rot_nx  = '0;
        scnt_nx = '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= '0;
      z0    <= 1'b0;
      rot   <= '0;
      scnt  <= '0;
    end else begin
      state <= state_nx;
      z0    <= z0_nx;
      rot   <= rot_nx;
      scnt  <= scnt_nx;
    end
  end

  assign STATE  = state;
  assign Z      = {state == LAST, z0};
  assign LED_SW = {Z, sw_sync};

  // Unrotated message: base[NUM_DIGITS-1] is the leftmost character.
  always_comb begin
    int k;
    k = int'(state);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      base[i] = 8'h20;
    end
    if (state == '0) begin
      base[3] = "I";
      base[2] = "d";
      base[1] = "L";
      base[0] = "E";
    end else begin
      base[3] = "S";
      base[2] = "_";
      base[1] = 8'(48 + k / 10);
      base[0] = 8'(48 + k % 10);
    end
  end

  always_comb begin
    CHARS = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      CHARS[8*i +: 8] = base[rot_t'((i + NUM_DIGITS - int'(rot)) % NUM_DIGITS)];
    end
  end

endmodule

// File: tb/tb_fsm_step_display.sv
// Directed bench for fsm_step_display: expectations are queued when a stimulus
// is applied and compared when the DUT output is due.
module tb_fsm_step_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key0;
  logic [4:0]  sw;
  logic [2:0]  state;
  logic [1:0]  z;
  logic [31:0] chars;
  logic [6:0]  led_sw;

  always #5 clk = ~clk;

  fsm_step_display #(
    .NUM_STATES(5), .NUM_DIGITS(4), .NUM_SW(5),
    .DEBOUNCE_CYCLES(4), .SCROLL_CYCLES(3)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY0(key0), .SW(sw),
    .STATE(state), .Z(z), .CHARS(chars), .LED_SW(led_sw)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [1:0]  z;
    logic [31:0] ch;
    logic [6:0]  led;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         m_state;
  logic       m_z0;
  int         m_rot;
  logic [4:0] m_swv;

  // Message as a left-to-right string, rotated left by rot places.
  function automatic logic [31:0] expChars(input int st, input int rot);
    string       s;
    logic [31:0] v;
    s = (st == 0) ? "IdLE" : $sformatf("S_%02d", st);
    v = '0;
    for (int j = 0; j < 4; j++) v[31-8*j -: 8] = s[(j + rot) % 4];
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic key, input logic [4:0] swv);
    key0  = key;
    sw    = swv;
    m_swv = swv;
  endtask

  task automatic pushExpected(input string tag);
    exp_t e;
    e.tag = tag;
    e.st  = 3'(m_state);
    e.z   = {m_state == 4, m_z0};
    e.ch  = expChars(m_state, m_rot);
    e.led = {e.z, m_swv};
    sb.push_back(e);
  endtask

  task automatic modelClear();
    m_state = 0;
    m_z0    = 1'b0;
    m_rot   = 0;
  endtask

  task automatic modelStep();
    if (!m_swv[3] && !m_swv[1]) begin
      if (m_swv[0]) begin
        m_z0    = (m_state == 4);
        m_state = (m_state == 4) ? 0 : m_state + 1;
      end else begin
        m_z0    = (m_state == 0);
        m_state = (m_state == 0) ? 4 : m_state - 1;
      end
      m_rot = 0;
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("[TB] FAIL scoreboard_empty: observed no expectation, expected one queued");
      return;
    end
    e = sb.pop_front();
    n_assert++;
    assert (state === e.st) else begin
      n_fail++;
      $error("[TB] FAIL %s.state: observed %0d expected %0d", e.tag, state, e.st);
    end
    n_assert++;
    assert (z === e.z) else begin
      n_fail++;
      $error("[TB] FAIL %s.z: observed %b expected %b", e.tag, z, e.z);
    end
    n_assert++;
    assert (chars === e.ch) else begin
      n_fail++;
      $error("[TB] FAIL %s.chars: observed \"%s\" expected \"%s\"", e.tag, chars, e.ch);
    end
    n_assert++;
    assert (led_sw === e.led) else begin
      n_fail++;
      $error("[TB] FAIL %s.led_sw: observed %b expected %b", e.tag, led_sw, e.led);
    end
  endtask

  // Clean press: result due 8 cycles after KEY0 falls, then hold and release.
  task automatic pressKey(input string tag);
    modelStep();
    pushExpected(tag);
    applyStimulus(1'b0, m_swv);
    cyc(8);
    checkOutput();
    cyc(2);
    applyStimulus(1'b1, m_swv);
    cyc(10);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'b00000);
    modelClear();
    cyc(3);
    pushExpected("reset");
    checkOutput();

    rst_n = 1'b1;
    applyStimulus(1'b1, 5'b00001);
    cyc(3);
    pushExpected("idle_fwd");
    checkOutput();

    $display("[TB] first press, exact latency, 10-cycle hold");
    pushExpected("latency_pre");
    modelStep();
    pushExpected("first_step");
    applyStimulus(1'b0, m_swv);
    cyc(7);
    checkOutput();
    cyc(1);
    checkOutput();
    cyc(2);
    applyStimulus(1'b1, m_swv);
    cyc(10);
    pushExpected("held_once");
    checkOutput();

    $display("[TB] bouncing press");
    pushExpected("bounce_pre");
    modelStep();
    pushExpected("bounce_step");
    for (int b = 0; b < 2; b++) begin
      applyStimulus(1'b0, m_swv);
      cyc(2);
      applyStimulus(1'b1, m_swv);
      cyc(2);
    end
    applyStimulus(1'b0, m_swv);
    cyc(7);
    checkOutput();
    cyc(1);
    checkOutput();
    cyc(2);
    applyStimulus(1'b1, m_swv);
    cyc(10);

    $display("[TB] forward ring and wrap flag");
    applyStimulus(1'b1, 5'b01001);
    modelClear();
    cyc(3);
    pushExpected("clear");
    checkOutput();
    applyStimulus(1'b1, 5'b00001);
    cyc(3);
    for (int p = 0; p < 5; p++) pressKey($sformatf("fwd%0d", p + 1));
    pressKey("fwd_after_wrap");

    $display("[TB] backward wrap and hold");
    applyStimulus(1'b1, 5'b01000);
    modelClear();
    cyc(3);
    pushExpected("clear2");
    checkOutput();
    applyStimulus(1'b1, 5'b00000);
    cyc(3);
    pressKey("back_wrap");
    applyStimulus(1'b1, 5'b00010);
    cyc(3);
    pressKey("hold_at4");
    applyStimulus(1'b1, 5'b00000);
    cyc(3);
    pressKey("back_to3");
    applyStimulus(1'b1, 5'b00011);
    cyc(3);
    pressKey("hold_at3");

    $display("[TB] clear during debounce");
    applyStimulus(1'b0, 5'b00001);
    cyc(4);
    applyStimulus(1'b0, 5'b01001);
    modelClear();
    pushExpected("clear_mid_debounce");
    cyc(4);
    checkOutput();
    cyc(6);
    pushExpected("clear_step_ignored");
    checkOutput();
    applyStimulus(1'b1, m_swv);
    cyc(10);
    pressKey("press_while_clear");
    applyStimulus(1'b1, 5'b00001);
    cyc(3);
    pushExpected("clear_released");
    checkOutput();
    pressKey("to1");
    pressKey("to2");

    $display("[TB] scrolling");
    applyStimulus(1'b1, 5'b00101);
    cyc(4);
    pushExpected("rot0");
    checkOutput();
    for (int r = 1; r <= 4; r++) begin
      cyc((r == 1) ? 1 : 3);
      m_rot = r % 4;
      pushExpected($sformatf("rot_tick%0d", r));
      checkOutput();
    end
    m_rot = 2;
    pushExpected("scroll_pre_step");
    modelStep();
    pushExpected("scroll_step");
    pushExpected("scroll_rot_cleared");
    m_rot = 1;
    pushExpected("scroll_resume");
    applyStimulus(1'b0, m_swv);
    cyc(7);
    checkOutput();
    cyc(1);
    checkOutput();
    cyc(2);
    checkOutput();
    cyc(1);
    checkOutput();
    applyStimulus(1'b1, m_swv);
    cyc(10);

    $display("[TB] asynchronous reset mid-press and mid-scroll");
    applyStimulus(1'b0, m_swv);
    cyc(5);
    #2;
    rst_n = 1'b0;
    modelClear();
    m_swv = 5'b00000;
    pushExpected("async_reset");
    #1;
    checkOutput();
    applyStimulus(1'b0, 5'b00001);
    cyc(2);
    rst_n = 1'b1;
    cyc(15);
    pushExpected("held_through_reset");
    checkOutput();
    applyStimulus(1'b1, m_swv);
    cyc(12);
    pressKey("fresh_press");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
